program_sequencer: RTL

//  Fetches 20-bit instructions from a synchronous program ROM and issues them to the Excutor datapath.
//  It owns the OpCode bus and interprets three control opcodes itself: NOP, conditional branch and HALT.
//  It captures the executor's Sign/Zero flags on completion of each instruction.

---
 rtl/seq_pkg.sv | 41 ++++
 rtl/seq_cond_eval.sv | 22 ++
 rtl/program_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: opcode map, branch conditions,
// FSM state encoding and the flag-update rule.
package seq_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_LOAD_CONST = 4'h1;
  localparam logic [3:0] OP_LOAD_REG   = 4'h2;
  localparam logic [3:0] OP_ADD        = 4'h3;
  localparam logic [3:0] OP_SUB        = 4'h4;
  localparam logic [3:0] OP_AND        = 4'h5;
  localparam logic [3:0] OP_OR         = 4'h6;
  localparam logic [3:0] OP_MUL        = 4'h7;
  localparam logic [3:0] OP_XOR        = 4'h8;
  localparam logic [3:0] OP_NOT        = 4'h9;
  localparam logic [3:0] OP_CMP        = 4'hA;
  localparam logic [3:0] OP_SHL        = 4'hB;
  localparam logic [3:0] OP_SHR        = 4'hC;
  localparam logic [3:0] OP_NEG        = 4'hD;
  localparam logic [3:0] OP_BR         = 4'hE;
  localparam logic [3:0] OP_HALT       = 4'hF;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_S  = 2'b10;
  localparam logic [1:0] COND_NZ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // Loads and shifts leave the flags alone; arithmetic/logic ops update them.
  function automatic logic flag_writer(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_CMP)) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/seq_cond_eval.sv
// Branch condition evaluator: decides whether a BR is taken from the latched flags.
module seq_cond_eval
  import seq_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       flag_z,
  input  logic       flag_s,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_AL: take = 1'b1;
      COND_Z:  take = flag_z;
      COND_S:  take = flag_s;
      COND_NZ: take = ~flag_z;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetches instructions from a program ROM, handles NOP/BR/HALT locally and
// issues every other opcode to the executor, with a watchdog on executor completion.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int A       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Start,
  output logic [A-1:0] ProgAddr,
  input  logic [19:0]  ProgData,
  output logic [19:0]  OpCode,
  input  logic         ExecDone,
  input  logic         ExecSign,
  input  logic         ExecZero,
  output logic         FlagS,
  output logic         FlagZ,
  output logic         Running,
  output logic         Halted,
  output logic         Fault,
  output logic [15:0]  InstrCount,
  output logic [2:0]   dbg_state
);

  state_t       state, next_state;
  logic [A-1:0] pc, pc_inc;
  logic [19:0]  ir;
  logic [3:0]   wdog;
  logic [3:0]   dec_op;
  logic         br_take;
  logic         wd_expired;

  assign dec_op     = ProgData[19:16];
  assign pc_inc     = pc + A'(1);
  assign wd_expired = (wdog == 4'(TIMEOUT - 1));
  assign dbg_state  = state;

  seq_cond_eval u_cond (
    .cond   (ProgData[9:8]),
    .flag_z (FlagZ),
    .flag_s (FlagS),
    .take   (br_take)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_HALTED: if (Start) next_state = S_FETCH;
      S_FETCH:          next_state = S_DECODE;
      S_DECODE: begin
        if ((dec_op == OP_NOP) || (dec_op == OP_BR)) next_state = S_FETCH;
        else if (dec_op == OP_HALT)                  next_state = S_HALTED;
        else                                         next_state = S_ISSUE;
      end
      S_ISSUE:          next_state = S_WAIT;
      S_WAIT: begin
        if (ExecDone)        next_state = S_FETCH;
        else if (wd_expired) next_state = S_HALTED;
      end
      default:          next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pc         <= '0;
      ProgAddr   <= '0;
      ir         <= '0;
      wdog       <= '0;
      FlagS      <= 1'b0;
      FlagZ      <= 1'b0;
      Fault      <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            pc         <= '0;
            FlagS      <= 1'b0;
            FlagZ      <= 1'b0;
            Fault      <= 1'b0;
            InstrCount <= '0;
          end
        end
        S_FETCH: ProgAddr <= pc;
        S_DECODE: begin
          ir <= ProgData;
          if (dec_op == OP_NOP) begin
            pc         <= pc_inc;
            InstrCount <= InstrCount + 16'd1;
          end else if (dec_op == OP_BR) begin
            pc         <= br_take ? ProgData[A-1:0] : pc_inc;
            InstrCount <= InstrCount + 16'd1;
          end else if (dec_op == OP_HALT) begin
            InstrCount <= InstrCount + 16'd1;
          end
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (ExecDone) begin
            pc         <= pc_inc;
            InstrCount <= InstrCount + 16'd1;
            if (flag_writer(ir[19:16])) begin
              FlagS <= ExecSign;
              FlagZ <= ExecZero;
            end
          end else if (wd_expired) begin
            Fault <= 1'b1;
          end else begin
            wdog <= wdog + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Executor handshake: a nonzero OpCode at an edge while Done=1 starts the op
  // (Done falls); OpCode is zeroed as soon as Done rises so the op cannot restart.
  always_comb begin
    OpCode  = '0;
    Running = 1'b0;
    Halted  = 1'b0;
    case (state)
      S_ISSUE: OpCode = ir;
      S_WAIT:  if (!ExecDone) OpCode = ir;
      default: ;
    endcase
    Running = (state == S_FETCH) || (state == S_DECODE) ||
              (state == S_ISSUE) || (state == S_WAIT);
    Halted  = (state == S_HALTED);
  end

endmodule
